pause_dim_ctrl: RTL and testbench

PAUSE_DIM_CTRL -- requirements
Module: pause_dim_ctrl

---
 rtl/sys1_video_pkg.sv | 26 ++
 rtl/pause_edge_sync.sv | 27 ++
 rtl/pause_dim_ctrl.sv | 117 +++++++++++
 tb/tb_pause_dim_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys1_video_pkg.sv
// rtl/sys1_video_pkg.sv - shared pause FSM states and RGB332 helpers
package sys1_video_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_COUNT   = 2'd1,
        ST_DIM_REQ = 2'd2
    } pause_state_e;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    // Halve each colour field independently so no bit bleeds across fields.
    function automatic logic [RGB_W-1:0] rgb332_dim(input logic [RGB_W-1:0] px);
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
        r = px[RGB_W-1 -: R_W];
        g = px[G_W+B_W-1 -: G_W];
        b = px[B_W-1:0];
        return {r >> 1, g >> 1, b >> 1};
    endfunction

endpackage

// File: rtl/pause_edge_sync.sv
// rtl/pause_edge_sync.sv - two-flop synchronizer with rising-edge pulse
module pause_edge_sync (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~prev_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// rtl/pause_dim_ctrl.sv - pause toggle, idle-dim timer and one-pixel video stage
module pause_dim_ctrl
    import sys1_video_pkg::*;
#(
    parameter int unsigned DIM_CYCLES = 480000000,
    parameter int unsigned TMR_W      = 32
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic             pause_btn,
    input  logic             osd_open,
    input  logic             osd_pause_en,
    input  logic             hs_access,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             pause,
    output logic             user_paused,
    output logic             dim
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIM_CYCLES - 1);

    logic             btn_rise;
    pause_state_e     state;
    pause_state_e     state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             frame_edge;

    pause_edge_sync u_edge (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .din     (pause_btn),
        .rise    (btn_rise)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            user_paused <= 1'b0;
        end else if (btn_rise) begin
            user_paused <= ~user_paused;
        end
    end

    assign pause = hs_access | user_paused | (osd_open & osd_pause_en);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!user_paused) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN:     state_nxt = ST_COUNT;
                ST_COUNT:   if (tmr == TMR_LAST) state_nxt = ST_DIM_REQ;
                ST_DIM_REQ: state_nxt = ST_DIM_REQ;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    // Saturates at TMR_LAST so a long pause can never wrap back below the threshold.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else begin
            case (state)
                ST_COUNT: if (tmr != TMR_LAST) tmr <= tmr + 1'b1;
                ST_DIM_REQ: tmr <= TMR_LAST;
                default:  tmr <= '0;
            endcase
        end
    end

    // vblank_out is exactly the previously sampled vblank_in, so it doubles as the edge history.
    assign frame_edge = ce_pix & vblank_in & ~vblank_out;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dim <= 1'b0;
        end else if (frame_edge) begin
            dim <= (state == ST_DIM_REQ);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out    <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
        end else if (ce_pix) begin
            rgb_out    <= dim ? rgb332_dim(rgb_in) : rgb_in;
            hblank_out <= hblank_in;
            vblank_out <= vblank_in;
            hs_out     <= hs_in;
            vs_out     <= vs_in;
        end
    end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// tb/tb_pause_dim_ctrl.sv - directed scoreboard bench for pause_dim_ctrl
module tb_pause_dim_ctrl;
    import sys1_video_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic       pause_btn;
    logic       osd_open;
    logic       osd_pause_en;
    logic       hs_access;
    logic [7:0] rgb_in;
    logic       hblank_in;
    logic       vblank_in;
    logic       hs_in;
    logic       vs_in;
    logic [7:0] rgb_out;
    logic       hblank_out;
    logic       vblank_out;
    logic       hs_out;
    logic       vs_out;
    logic       pause;
    logic       user_paused;
    logic       dim;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb[$];
    logic [11:0] last_exp;
    logic        m_dim;
    logic        m_vb_prev;
    logic        m_dimreq;

    pause_dim_ctrl #(.DIM_CYCLES(16), .TMR_W(8)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .pause_btn    (pause_btn),
        .osd_open     (osd_open),
        .osd_pause_en (osd_pause_en),
        .hs_access    (hs_access),
        .rgb_in       (rgb_in),
        .hblank_in    (hblank_in),
        .vblank_in    (vblank_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .rgb_out      (rgb_out),
        .hblank_out   (hblank_out),
        .vblank_out   (vblank_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .pause        (pause),
        .user_paused  (user_paused),
        .dim          (dim)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] half_px(input logic [7:0] x);
        return {1'b0, x[7:6], 1'b0, x[4:3], 1'b0, x[1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
    endtask

    // Drives one ce_pix cycle, predicts the registered output and dim, then checks both.
    task automatic pix(input logic [7:0] rgb, input logic hb, input logic vb,
                       input logic hs, input logic vs);
        logic [11:0] exp;
        rgb_in = rgb; hblank_in = hb; vblank_in = vb; hs_in = hs; vs_in = vs;
        ce_pix = 1'b1;
        sb.push_back({(m_dim ? half_px(rgb) : rgb), hb, vb, hs, vs});
        if (vb && !m_vb_prev) m_dim = m_dimreq;
        m_vb_prev = vb;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ce_pix = 1'b0;
        exp = sb.pop_front();
        last_exp = exp;
        chk("video", {20'd0, rgb_out, hblank_out, vblank_out, hs_out, vs_out}, {20'd0, exp});
        chk("dim", {31'd0, dim}, {31'd0, m_dim});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_video"}, {20'd0, rgb_out, hblank_out, vblank_out, hs_out, vs_out},
            {20'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        chk({tag, "_user_paused"}, {31'd0, user_paused}, 32'd0);
        chk({tag, "_dim"}, {31'd0, dim}, 32'd0);
    endtask

    // Raises the button and waits (bounded) for the toggle; returns clocks taken.
    task automatic press(output int lat);
        logic start;
        start = user_paused;
        pause_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (user_paused != start && lat == 0) lat = i;
        end
        pause_btn = 1'b0;
        tick(1);
    endtask

    initial begin
        int lat;
        reset_n = 1'b0; ce_pix = 1'b0; pause_btn = 1'b0; osd_open = 1'b0;
        osd_pause_en = 1'b0; hs_access = 1'b0; rgb_in = 8'h00; hblank_in = 1'b1;
        vblank_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        m_dim = 1'b0; m_vb_prev = 1'b1; m_dimreq = 1'b0; last_exp = 12'h0;
        tick(3);
        chk_reset_outputs("reset");
        chk("reset_pause", {31'd0, pause}, 32'd0);
        chk("reset_state", 32'(dut.state), 32'(ST_RUN));
        reset_n = 1'b1;
        tick(2);

        pix(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        pix(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        pix(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        pix(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk("hold_no_ce", {20'd0, rgb_out, hblank_out, vblank_out, hs_out, vs_out}, {20'd0, last_exp});

        osd_open = 1'b1; osd_pause_en = 1'b0; #1;
        chk("osd_no_en", {31'd0, pause}, 32'd0);
        osd_pause_en = 1'b1; #1;
        chk("osd_en", {31'd0, pause}, 32'd1);
        osd_open = 1'b0; osd_pause_en = 1'b0; #1;
        chk("osd_off", {31'd0, pause}, 32'd0);

        hs_access = 1'b1;
        pix(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) pix(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
            else tick(1);
            chk("hs_pause", {31'd0, pause}, 32'd1);
            chk("hs_tmr", 32'(dut.tmr), 32'd0);
        end
        chk("hs_dim", {31'd0, dim}, 32'd0);
        chk("hs_state", 32'(dut.state), 32'(ST_RUN));
        hs_access = 1'b0;

        pix(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        pause_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            if (user_paused && lat == 0) lat = i;
        end
        pause_btn = 1'b0;
        chk("press_user_paused", {31'd0, user_paused}, 32'd1);
        chk("press_latency_le3", 32'(lat > 0 && lat <= 3), 32'd1);
        chk("press_pause", {31'd0, pause}, 32'd1);
        tick(3 - lat + 1);
        chk("count_entry", 32'(dut.state), 32'(ST_COUNT));
        chk("count_tmr0", 32'(dut.tmr), 32'd0);
        tick(15);
        chk("count_before_dim", 32'(dut.state), 32'(ST_COUNT));
        chk("count_tmr15", 32'(dut.tmr), 32'd15);
        tick(1);
        chk("dim_req", 32'(dut.state), 32'(ST_DIM_REQ));
        tick(10);
        chk("dim_req_tmr_hold", 32'(dut.tmr), 32'd15);
        m_dimreq = 1'b1;

        pix(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(8'h88, 1'b1, 1'b1, 1'b0, 1'b1);
        pix(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("dim_ff", {24'd0, rgb_out}, 32'h6D);
        pix(8'b100_010_10, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("dim_8a", {24'd0, rgb_out}, {24'd0, 8'b010_001_01});
        pix(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unpause toggle lands on the same clock as a vblank rise: dim must use the pre-edge state.
        pause_btn = 1'b1;
        tick(2);
        pause_btn = 1'b0;
        pix(8'h9A, 1'b1, 1'b1, 1'b0, 1'b0);
        m_dimreq = 1'b0;
        chk("unpause_user_paused", {31'd0, user_paused}, 32'd0);
        chk("unpause_dim_kept", {31'd0, dim}, 32'd1);
        tick(1);
        chk("unpause_run", 32'(dut.state), 32'(ST_RUN));
        chk("unpause_pause", {31'd0, pause}, 32'd0);
        pix(8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(8'hE7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("undim_after_frame", {31'd0, dim}, 32'd0);

        press(lat);
        chk("repress_user_paused", {31'd0, user_paused}, 32'd1);
        chk("repress_count", 32'(dut.state), 32'(ST_COUNT));
        pix(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("midcount");
        chk("midcount_pause", {31'd0, pause}, 32'd0);
        chk("midcount_state", 32'(dut.state), 32'(ST_RUN));
        hs_access = 1'b1; #1;
        chk("reset_hs_pause", {31'd0, pause}, 32'd1);
        hs_access = 1'b0; osd_open = 1'b1; osd_pause_en = 1'b1; #1;
        chk("reset_osd_pause", {31'd0, pause}, 32'd1);
        osd_open = 1'b0; osd_pause_en = 1'b0;
        sb.delete();
        m_dim = 1'b0; m_vb_prev = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        chk("post_reset_idle", {31'd0, user_paused}, 32'd0);
        chk("post_reset_state", 32'(dut.state), 32'(ST_RUN));
        press(lat);
        chk("post_reset_press", {31'd0, user_paused}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
